// File: rtl/audio_mixer.sv
// ============================================================================
// Module   : audio_mixer
// Brief    : Time-multiplexed stereo mixer (one channel per clock) feeding two
//            first-order sigma-delta DACs. Define AUDIO_MIXER_SATURATE_EN to
//            clip the mix instead of attenuating it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_mixer #(
   parameter int CHANNELS = 6,
   parameter int DW       = 8,
   parameter int OW       = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [CHANNELS*DW-1:0] din,
   input  logic [CHANNELS*4-1:0]  vol,
   input  logic [CHANNELS*2-1:0]  pan,
   output logic [OW-1:0]          sample_l,
   output logic [OW-1:0]          sample_r,
   output logic                   strobe,
   output logic [1:0]             audio
);

   localparam int AW   = (CHANNELS == 1) ? DW + 1 : DW + 1 + $clog2(CHANNELS);
   localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW   = DW + 1;
   localparam int OMAX = (1 << OW) - 1;
   localparam logic [IW-1:0] LAST_SLOT = IW'(CHANNELS - 1);

   logic [IW-1:0]   idx;
   logic [AW-1:0]   acc_l;
   logic [AW-1:0]   acc_r;
   logic [DW-1:0]   cur_din;
   logic [3:0]      cur_vol;
   logic [1:0]      cur_pan;
   logic [DW+3:0]   prod;
   logic [PW-1:0]   term;
   logic [AW-1:0]   sum_l;
   logic [AW-1:0]   sum_r;
   logic            last_slot;
   logic [OW:0]     dacc_l;
   logic [OW:0]     dacc_r;

   // Only the channel owning the current slot is looked at.
   always_comb begin
      cur_din = '0;
      cur_vol = '0;
      cur_pan = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == IW'(k)) begin
            cur_din = din[k*DW +: DW];
            cur_vol = vol[k*4 +: 4];
            cur_pan = pan[k*2 +: 2];
         end
      end
   end

   assign prod      = {4'b0000, cur_din} * {{DW{1'b0}}, cur_vol};
   assign term      = PW'(prod >> 3);
   assign sum_l     = acc_l + (cur_pan[0] ? AW'(term) : '0);
   assign sum_r     = acc_r + (cur_pan[1] ? AW'(term) : '0);
   assign last_slot = (idx == LAST_SLOT);

   function automatic logic [OW-1:0] scale(input logic [AW-1:0] s);
`ifdef AUDIO_MIXER_SATURATE_EN
      return (s > AW'(OMAX)) ? '1 : OW'(s);
`else
      return OW'(s >> (AW - OW));
`endif
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx      <= '0;
         acc_l    <= '0;
         acc_r    <= '0;
         sample_l <= '0;
         sample_r <= '0;
         strobe   <= 1'b0;
      end else if (last_slot) begin
         idx      <= '0;
         acc_l    <= '0;
         acc_r    <= '0;
         sample_l <= scale(sum_l);
         sample_r <= scale(sum_r);
         strobe   <= 1'b1;
      end else begin
         idx      <= idx + 1'b1;
         acc_l    <= sum_l;
         acc_r    <= sum_r;
         strobe   <= 1'b0;
      end
   end

   // The carry out of each DAC accumulator is the output bit; it is dropped
   // before the next addition so the residue keeps integrating.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dacc_l <= '0;
         dacc_r <= '0;
      end else begin
         dacc_l <= {1'b0, dacc_l[OW-1:0]} + {1'b0, sample_l};
         dacc_r <= {1'b0, dacc_r[OW-1:0]} + {1'b0, sample_r};
      end
   end

   assign audio = {dacc_r[OW], dacc_l[OW]};

endmodule

`default_nettype wire

// File: tb/tb_audio_mixer.sv
// ============================================================================
// Module   : tb_audio_mixer
// Brief    : Self-checking bench for audio_mixer with a frame-level reference
//            model and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_mixer;

   localparam int C    = 6;
   localparam int DW   = 8;
   localparam int OW   = 10;
   localparam int AW   = DW + 1 + $clog2(C);
   localparam int OMAX = (1 << OW) - 1;
   localparam longint DACM = 64'd1 << OW;

`ifdef AUDIO_MIXER_SATURATE_EN
   localparam int L1 = 255;
   localparam int L3 = 1023;
   localparam int L4 = 128;
`else
   localparam int L1 = 63;
   localparam int L3 = 717;
   localparam int L4 = 32;
`endif

   logic              clock;
   logic              reset;
   logic [C*DW-1:0]   din;
   logic [C*4-1:0]    vol;
   logic [C*2-1:0]    pan;
   logic [OW-1:0]     sample_l;
   logic [OW-1:0]     sample_r;
   logic              strobe;
   logic [1:0]        audio;

   audio_mixer #(.CHANNELS(C), .DW(DW), .OW(OW)) dut (
      .clock    (clock),
      .reset    (reset),
      .din      (din),
      .vol      (vol),
      .pan      (pan),
      .sample_l (sample_l),
      .sample_r (sample_r),
      .strobe   (strobe),
      .audio    (audio)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int ecount   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int     m_cnt = 0;
   int     m_l = 0, m_r = 0;
   int     exp_l = 0, exp_r = 0;
   bit     exp_strobe = 1'b0;
   bit [1:0] exp_audio = 2'b00;
   longint tot_l = 0, tot_r = 0;
   int     slot, d, v, p;

   function automatic int scale(input int s);
`ifdef AUDIO_MIXER_SATURATE_EN
      return (s > OMAX) ? OMAX : s;
`else
      return s >> (AW - OW);
`endif
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_l = 0; m_r = 0; exp_l = 0; exp_r = 0;
         exp_strobe = 1'b0; exp_audio = 2'b00; tot_l = 0; tot_r = 0;
      end else begin
         // DAC output bit = increase of floor(running total / 2^OW)
         exp_audio[0] = ((tot_l + exp_l) / DACM) != (tot_l / DACM);
         exp_audio[1] = ((tot_r + exp_r) / DACM) != (tot_r / DACM);
         tot_l += exp_l;
         tot_r += exp_r;
         slot = m_cnt % C;
         d = int'(din[slot*DW +: DW]);
         v = int'(vol[slot*4 +: 4]);
         p = (d * v) / 8;
         if (pan[slot*2])     m_l += p;
         if (pan[slot*2 + 1]) m_r += p;
         if (slot == C - 1) begin
            exp_l = scale(m_l);
            exp_r = scale(m_r);
            m_l = 0;
            m_r = 0;
            exp_strobe = 1'b1;
         end else begin
            exp_strobe = 1'b0;
         end
         m_cnt++;
      end
   end

   always @(posedge clock) begin
      #1;
      check("sample_l", sample_l, exp_l);
      check("sample_r", sample_r, exp_r);
      check("strobe", strobe, exp_strobe);
      check("audio", audio, exp_audio);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clock);
      ecount++;
   endtask

   task automatic set_ch(input int k, input int dv, input int vv, input int pv);
      din[k*DW +: DW] = DW'(dv);
      vol[k*4 +: 4]   = 4'(vv);
      pan[k*2 +: 2]   = 2'(pv);
   endtask

   task automatic rand_inputs(input bit with_pan);
      for (int k = 0; k < C; k++) begin
         din[k*DW +: DW] = DW'($urandom_range(0, 255));
         vol[k*4 +: 4]   = 4'($urandom_range(0, 15));
         pan[k*2 +: 2]   = with_pan ? 2'($urandom_range(0, 3)) : 2'b00;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      ecount = 0;
   endtask

   int ones;

   initial begin
      reset = 1'b1;
      rand_inputs(1'b0);
      set_ch(0, 8'hFF, 8, 3);
      repeat (3) @(negedge clock);
      check("reset_sample_l", sample_l, 0);
      check("reset_sample_r", sample_r, 0);
      check("reset_strobe", strobe, 0);
      check("reset_audio", audio, 0);

      // strobe cadence plus single loud channel
      reset = 1'b0;
      ecount = 0;
      repeat (18) begin
         tick();
         check("strobe_cadence", strobe, (ecount % C == 0) ? 1 : 0);
      end
      check("ch0_full_l", sample_l, L1);
      check("ch0_full_r", sample_r, L1);

      // all channels at maximum
      do_reset();
      for (int k = 0; k < C; k++) set_ch(k, 8'hFF, 15, 3);
      repeat (12) tick();
      check("all_max_l", sample_l, L3);
      check("all_max_r", sample_r, L3);

      // channel 2 left only; inputs off-slot are ignored
      do_reset();
      rand_inputs(1'b0);
      set_ch(2, 8'h80, 8, 1);
      repeat (6) tick();
      check("ch2_l", sample_l, L4);
      check("ch2_r", sample_r, 0);
      repeat (6) begin
         if (ecount % C == 2) begin
            din[2*DW +: DW] = 8'h80;
            vol[2*4 +: 4]   = 4'd8;
         end else begin
            din[2*DW +: DW] = DW'($urandom_range(0, 255));
            vol[2*4 +: 4]   = 4'($urandom_range(0, 15));
         end
         tick();
      end
      check("ch2_offslot_l", sample_l, L4);
      check("ch2_offslot_r", sample_r, 0);

      // DAC density with sample 256
      do_reset();
      rand_inputs(1'b0);
`ifdef AUDIO_MIXER_SATURATE_EN
      set_ch(0, 8'h80, 8, 1);
      set_ch(1, 8'h80, 8, 1);
`else
      set_ch(0, 8'hFF, 15, 1);
      set_ch(1, 8'hFF, 15, 1);
      set_ch(2, 8'h44, 8, 1);
`endif
      repeat (6) tick();
      check("dac_sample", sample_l, 256);
      ones = 0;
      repeat (6144) begin
         tick();
         ones += int'(audio[0]);
      end
      check("dac_ones_256", ones, 1536);

      // DAC with silence
      rand_inputs(1'b0);
      do_reset();
      ones = 0;
      repeat (600) begin
         tick();
         ones += int'(audio[0]);
      end
      check("dac_ones_0", ones, 0);

      // reset in slot 3 discards the partial frame
      rand_inputs(1'b1);
      for (int k = 0; k < C; k++) pan[k*2 +: 2] = 2'b11;
      do_reset();
      repeat (3) tick();
      reset = 1'b1;
      rand_inputs(1'b0);
      set_ch(0, 8'hFF, 8, 3);
      @(negedge clock);
      reset = 1'b0;
      ecount = 0;
      repeat (6) begin
         tick();
         check("post_reset_strobe", strobe, (ecount == 6) ? 1 : 0);
      end
      check("post_reset_l", sample_l, L1);
      check("post_reset_r", sample_r, L1);

      // randomized traffic with occasional mid-frame resets
      do_reset();
      for (int i = 0; i < 1800; i++) begin
         rand_inputs(1'b1);
         if ($urandom_range(0, 199) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
